// File: rtl/ifb_pkg.sv
// Shared types and constants for the instruction prefetch buffer.
// The optional same-cycle bypass path is enabled by defining IFB_BYPASS_EN.
package ifb_pkg;

    localparam int          IFB_XLEN   = 32;
    localparam int unsigned IFB_PC_INC = 4;

    // IDLE: nothing outstanding; WAIT: response will be kept; DROP: response will be discarded
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } ifb_state_e;

    typedef struct packed {
        logic [IFB_XLEN-1:0] pc;
        logic [31:0]         data;
    } ifb_entry_t;

endpackage

// File: rtl/ifb_fifo.sv
// Synchronous FIFO holding fetched {pc, data} entries.
// Flush has priority over push; a pop during flush is absorbed by the flush.
module ifb_fifo
    import ifb_pkg::*;
#(
    parameter  int WIDTH = $bits(ifb_entry_t),
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (count_q != CNT_W'(DEPTH));
    assign do_pop  = pop && (count_q != '0);

    // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two.
    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage write.
    // NOTE: the storage array has no reset; an entry is only read after count marks it valid.
    always_ff @(posedge clk) begin
        if (!reset && !flush && do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/ifetch_prefetch_buffer.sv
// Instruction prefetch buffer: sequential fetch with one request outstanding,
// FIFO of {pc, data} toward the fetch stage, flush on taken-branch redirect.
// Define IFB_BYPASS_EN to forward a response straight to the fetch stage when the FIFO is empty.
module ifetch_prefetch_buffer
    import ifb_pkg::*;
#(
    parameter int              XLEN     = IFB_XLEN,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_pc,
    output logic [31:0]     inst_data
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    ifb_state_e       state_q, state_d;
    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]  req_pc_q, req_pc_d;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_valid;
    logic             bypass;
    logic [XLEN+31:0] head;
    logic [CNT_W-1:0] count;

    // State, fetch PC and outstanding-request PC registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
        end
    end

    // Next-state, request issue and FIFO push decision.
    // NOTE: every signal driven here gets a default first so no latch can be inferred.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        imem_req   = 1'b0;
        fifo_push  = 1'b0;
        unique case (state_q)
            IDLE: begin
                imem_req = !reset && !redirect && (count < CNT_W'(DEPTH));
                if (imem_req && imem_gnt) begin
                    req_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + XLEN'(IFB_PC_INC);
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    // A word already taken through the bypass must not be queued again.
                    fifo_push = !redirect && !(bypass && inst_ready);
                    state_d   = IDLE;
                end else if (redirect) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (imem_rvalid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (redirect) fetch_pc_d = redirect_pc & ~XLEN'(3);
    end

    ifb_fifo #(
        .WIDTH (XLEN + 32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect),
        .push      (fifo_push),
        .push_data ({req_pc_q, imem_rdata}),
        .pop       (fifo_pop),
        .head_data (head),
        .count     (count)
    );

    assign imem_addr  = fetch_pc_q;
    assign fifo_valid = (count != '0);
    assign fifo_pop   = fifo_valid && inst_ready;

`ifdef IFB_BYPASS_EN
    assign bypass     = (state_q == WAIT) && (count == '0) && imem_rvalid && !redirect;
    assign inst_valid = fifo_valid || bypass;
    assign inst_pc    = bypass ? req_pc_q   : (fifo_valid ? head[XLEN+31:32] : '0);
    assign inst_data  = bypass ? imem_rdata : (fifo_valid ? head[31:0]       : '0);
`else
    assign bypass     = 1'b0;
    assign inst_valid = fifo_valid;
    assign inst_pc    = fifo_valid ? head[XLEN+31:32] : '0;
    assign inst_data  = fifo_valid ? head[31:0]       : '0;
`endif

endmodule

// File: tb/tb_ifetch_prefetch_buffer.sv
// Self-checking bench for ifetch_prefetch_buffer with a scoreboard of expected {pc, data}.
// Honours IFB_BYPASS_EN for the expected first-word latency and valid timing.
module tb_ifetch_prefetch_buffer;
    import ifb_pkg::*;

    localparam int DEPTH = 4;
`ifdef IFB_BYPASS_EN
    localparam int EXP_LAT = 1;
`else
    localparam int EXP_LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_pc;
    logic [31:0] inst_data;

    always #5 clk = ~clk;

    ifetch_prefetch_buffer #(
        .XLEN     (32),
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst_pc     (inst_pc),
        .inst_data   (inst_data)
    );

    ifb_entry_t  sb[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    bit          gnt_v = 1'b0, ready_v = 1'b0, pp_mode = 1'b0, stale = 1'b0;
    int          lat = 1;
    bit          pend = 1'b0, killed = 1'b0, prev_redir = 1'b0;
    int          cnt = 0;
    logic [31:0] pend_addr = '0, exp_fetch = '0;
    int          cyc = 0, first_gnt = -1, first_valid = -1, n_gnt = 0, pops = 0, pp_events = 0;
    logic        last_req = 1'b0;
    logic [31:0] last_addr = '0;

    // addi x(n), x0, n for the word at address 4*n
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] n;
        n = a >> 2;
        return 32'h13 | (n << 20) | ((n & 32'h1f) << 7);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic cycle(input bit redir, input logic [31:0] rpc);
        bit         rsp;
        int         sz_before;
        logic       exp_valid;
        ifb_entry_t e;
        @(negedge clk);
        rsp = pend && (cnt == 1);
        if (pend && cnt > 1) cnt--;
        imem_rvalid = rsp || stale;
        stale       = 1'b0;
        imem_rdata  = rsp ? mem_word(pend_addr) : $urandom();
        redirect    = redir;
        redirect_pc = rpc;
        imem_gnt    = gnt_v;
        inst_ready  = pp_mode ? (sb.size() == 3 && rsp && !killed) : ready_v;
        #1;
        cyc++;
        sz_before = sb.size();
        if (prev_redir)          check("valid_after_redirect", 32'(inst_valid), 32'h0);
        if (redir)               check("req_in_redirect", 32'(imem_req), 32'h0);
        if (sz_before == DEPTH)  check("req_when_full", 32'(imem_req), 32'h0);
        if (imem_req) begin
            check("single_outstanding", 32'(pend), 32'h0);
            check("imem_addr", imem_addr, exp_fetch);
        end
        if (rsp) begin
            if (!killed && !redir) sb.push_back(ifb_entry_t'{pc: pend_addr, data: mem_word(pend_addr)});
            pend = 1'b0;
        end
`ifdef IFB_BYPASS_EN
        exp_valid = (sb.size() != 0);
`else
        exp_valid = (sz_before != 0);
`endif
        check("inst_valid", 32'(inst_valid), 32'(exp_valid));
        if (inst_valid && sb.size() != 0) begin
            e = sb[0];
            check("inst_pc", inst_pc, e.pc);
            check("inst_data", inst_data, e.data);
            if (first_valid < 0) first_valid = cyc;
            if (inst_ready) begin
                void'(sb.pop_front());
                pops++;
                if (pp_mode && rsp && sz_before == 3) pp_events++;
            end
        end
        if (imem_req && imem_gnt) begin
            pend      = 1'b1;
            killed    = 1'b0;
            cnt       = lat;
            pend_addr = exp_fetch;
            exp_fetch = exp_fetch + 32'd4;
            n_gnt++;
            if (first_gnt < 0) first_gnt = cyc;
        end
        if (redir) begin
            sb.delete();
            exp_fetch = rpc & ~32'h3;
            if (pend) killed = 1'b1;
        end
        prev_redir = redir;
        last_req   = imem_req;
        last_addr  = imem_addr;
    endtask

    task automatic tick();
        cycle(1'b0, 32'h0);
    endtask

    task automatic wait_pend();
        int i = 0;
        while (!pend && i < 20) begin
            tick();
            i++;
        end
        check("wait_grant", 32'(pend), 32'h1);
    endtask

    task automatic wait_req(input logic [31:0] exp, input string tag);
        int i = 0;
        do begin
            tick();
            i++;
        end while (!last_req && i < 40);
        check({tag, "_seen"}, 32'(last_req), 32'h1);
        check(tag, last_addr, exp);
    endtask

    task automatic drain();
        int i = 0;
        gnt_v   = 1'b0;
        ready_v = 1'b1;
        while ((sb.size() != 0 || pend) && i < 50) begin
            tick();
            i++;
        end
        check("drain", 32'(sb.size()) + 32'(pend), 32'h0);
        gnt_v = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        inst_ready  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset_req", 32'(imem_req), 32'h0);
        check("reset_valid", 32'(inst_valid), 32'h0);
        check("reset_pc", inst_pc, 32'h0);
        check("reset_data", inst_data, 32'h0);
        reset     = 1'b0;
        stale     = 1'b1;
        exp_fetch = 32'h0;

        // Stalled consumer: exactly DEPTH fetches, then requests stop; head stays at 0x0.
        gnt_v   = 1'b1;
        ready_v = 1'b0;
        lat     = 1;
        repeat (20) tick();
        check("fills_to_depth", 32'(n_gnt), 32'd4);
        check("req_idle_when_full", 32'(last_req), 32'h0);
        check("first_latency", 32'(first_valid - first_gnt), 32'(EXP_LAT));

        // Consumer ready: drain 0x0..0xC and keep streaming from 0x10.
        ready_v = 1'b1;
        repeat (30) tick();
        check("stream_progress", 32'(pops >= 10), 32'h1);

        // Redirect while a response is outstanding, then again while dropping it.
        lat = 3;
        wait_pend();
        cycle(1'b1, 32'h100);
        cycle(1'b1, 32'h200);
        wait_req(32'h200, "drop_redirect_addr");
        lat = 1;
        repeat (10) tick();

        // Redirect in the same cycle as the response.
        wait_pend();
        cycle(1'b1, 32'h40);
        wait_req(32'h40, "rsp_redirect_addr");
        repeat (6) tick();

        // Unaligned target and address wrap at the top of the space.
        cycle(1'b1, 32'h103);
        wait_req(32'h100, "align_addr");
        repeat (6) tick();
        cycle(1'b1, 32'hFFFF_FFFC);
        wait_req(32'hFFFF_FFFC, "top_addr");
        wait_req(32'h0, "wrap_addr");
        repeat (6) tick();

        // Push and pop together at count 3.
        drain();
        pp_mode = 1'b1;
        repeat (40) tick();
        check("push_pop_at_3", 32'(pp_events > 0), 32'h1);
        pp_mode = 1'b0;
        ready_v = 1'b1;
        repeat (20) tick();
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ifetch_prefetch_buffer.md
Name: ifetch_prefetch_buffer

Overview:
- Instruction prefetch buffer between the instruction-memory port and the fetch stage.
- Issues sequential fetch requests over a request/grant, response-valid memory protocol, with one request outstanding at most.
- Queues returned words tagged with their PC in a small FIFO and delivers them to the fetch stage on a valid/ready handshake.
- A taken-branch redirect (PCSrc, target PC from the memory stage) flushes the queue and discards any in-flight response.

Parameters:
- XLEN, 32, data and address width.
- DEPTH, 4, FIFO entries; a power of two, at least 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock.
- reset  in  1  reset.
- redirect  in  1  taken branch (PCSrc); flush and refetch.
- redirect_pc  in  XLEN  new fetch target.
- imem_req  out  1  fetch request.
- imem_addr  out  XLEN  fetch address, word aligned.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response data valid.
- imem_rdata  in  32  returned instruction word.
- inst_valid  out  1  head entry valid.
- inst_ready  in  1  fetch stage consumes the head entry.
- inst_pc  out  XLEN  PC of the head entry.
- inst_data  out  32  instruction of the head entry.

Behaviour:
- One clock (clk), rising edge. reset is synchronous and active-high.
- Reset state: state IDLE, count 0, fetch_pc RESET_PC. Outputs: imem_req 0, inst_valid 0, inst_pc 0, inst_data 0.
- FSM states: IDLE (nothing outstanding), WAIT (outstanding, keep data), DROP (outstanding, discard data).
- IDLE:
  - imem_req = 1 when !redirect and count < DEPTH.
  - On imem_req && imem_gnt: latch req_pc = fetch_pc, set fetch_pc += 4, go to WAIT.
  - Without a grant, imem_req and imem_addr hold stable.
- WAIT:
  - imem_req = 0.
  - On imem_rvalid && !redirect: push {req_pc, imem_rdata}, go to IDLE.
  - On redirect && imem_rvalid: discard the data, go to IDLE.
  - On redirect && !imem_rvalid: go to DROP.
- DROP:
  - imem_req = 0.
  - On imem_rvalid: discard the data, go to IDLE.
  - A further redirect in DROP only updates fetch_pc.
- imem_rvalid in IDLE is ignored. This covers stale responses after reset.
- Redirect handling (any state):
  - FIFO count goes to 0 and fetch_pc = {redirect_pc[XLEN-1:2], 2'b00}, both next cycle.
  - inst_valid is 0 the following cycle.
  - A pop in the redirect cycle is still honoured; the consumer's handshake stands.
- Pop when inst_valid && inst_ready. Push and pop in the same cycle leave count unchanged.
- inst_valid = (count != 0). inst_pc and inst_data show the head entry and stay stable while valid && !ready.
- Full: no request is issued when count == DEPTH. Only one request is ever outstanding, so a response can never overflow the FIFO.
- Wrap-around:
  - fetch_pc wraps modulo 2^XLEN (0xFFFF_FFFC + 4 = 0).
  - FIFO pointers wrap modulo DEPTH.
- Latency: a grant in cycle N with rvalid in N+1 gives inst_valid in N+2. The next request is in N+2 at the earliest.
- Reset in mid-transaction drops all state. The responding memory is reset by the same signal.

Optional Feature:
- IFB_BYPASS_EN defined:
  - In WAIT with count == 0, imem_rvalid and !redirect, inst_valid = 1 in the same cycle, with inst_pc = req_pc and inst_data = imem_rdata.
  - If inst_ready is also high, the word is not pushed.
  - Latency becomes grant + 1.
- Undefined: all data passes through the FIFO, and outputs come only from registers or the FIFO head.

Decomposition:
- Package ifb_pkg holds:
  - the state enum (IDLE, WAIT, DROP);
  - the XLEN default;
  - the PC increment constant 4;
  - the entry struct {pc, data}.
- Sub-module ifb_fifo: synchronous FIFO, DEPTH entries, with push, pop, flush and count. Flush has priority over push; a pop in the flush cycle is harmless.

Test Plan:
- Reset; memory gnt=1, rvalid one cycle later returning 0x00000013, 0x00100093, ...; inst_ready=1 -> inst_pc 0x0, 0x4, 0x8 in order, with the first inst_valid two cycles after the first grant.
- inst_ready=0 for 20 cycles -> exactly 4 fetches (0x0 to 0xC), then imem_req stays 0. Head holds inst_pc 0x0 stable. Raising ready drains 0x0 to 0xC and fetching resumes at 0x10.
- Grant for 0x8, then redirect with redirect_pc=0x100 before rvalid -> the late response is discarded, inst_valid=0, the next imem_addr is 0x100 and the first delivered inst_pc is 0x100.
- Redirect in the same cycle as rvalid -> the word is discarded, with no entry for the old PC; the next fetch is redirect_pc.
- redirect_pc=0x103 -> imem_addr 0x100. Redirect to 0xFFFF_FFFC -> the following fetch addresses 0x0.
- count=3, push and pop in the same cycle -> count stays 3 and order is preserved. With IFB_BYPASS_EN, empty FIFO plus ready -> inst_valid in the rvalid cycle.
